memory_responder: RTL

- Target (responder) end of the core's single-port memory handshake (valid/instr/addr/wdata/wstrb -> rdata/ready).
- Serves word-addressed on-chip RAM with a configurable wait-state count.
- Contains a CLINT-style timer/software-interrupt register block that drives the core's timer_irpt and soft_irpt inputs.
- Instantiated beside the core in the SoC top and in simulation benches in place of an external memory model.

---
 rtl/memory_responder_pkg.sv | 37 +++
 rtl/memory_responder_clint.sv | 80 ++++++++
 rtl/memory_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder.
// FSM states, region select and CLINT register offsets.
package memory_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        R_RAM,
        R_CLINT,
        R_NONE
    } region_t;

    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    // Replace only the strobed byte lanes of old with wdata.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/memory_responder_clint.sv
// CLINT-style timer and software interrupt registers.
// Accessed through a one-cycle strobe from the responder FSM.
module memory_responder_clint
    import memory_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        rd,
    input  logic [15:0] off,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        timer_irpt,
    output logic        soft_irpt
);

    logic        msip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    // msip and mtimecmp register writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
        end else if (wr) begin
            case (off)
                OFF_MSIP: begin
                    if (wstrb[0]) msip <= wdata[0];
                end
                OFF_MTIMECMP_LO:
                    mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wdata, wstrb);
                OFF_MTIMECMP_HI:
                    mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, wstrb);
                default: ;
            endcase
        end
    end

    // mtime free-runs; a write to either half holds the count that cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else if (wr && off == OFF_MTIME_LO) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], wdata, wstrb);
        end else if (wr && off == OFF_MTIME_HI) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wstrb);
        end else begin
            mtime <= mtime + 64'd1;
        end
    end

    // registered interrupt outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_irpt <= 1'b0;
            soft_irpt  <= 1'b0;
        end else begin
            timer_irpt <= (mtime >= mtimecmp);
            soft_irpt  <= msip;
        end
    end

    // read mux, zero outside a read strobe or on unknown offsets
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (off)
                OFF_MSIP:        rdata = {31'd0, msip};
                OFF_MTIMECMP_LO: rdata = mtimecmp[31:0];
                OFF_MTIMECMP_HI: rdata = mtimecmp[63:32];
                OFF_MTIME_LO:    rdata = mtime[31:0];
                OFF_MTIME_HI:    rdata = mtime[63:32];
                default:         rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Responder end of the core memory handshake.
// RAM with wait states plus a CLINT register window.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int          RAM_DEPTH  = 16384,
    parameter int          WAIT       = 1,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        timer_irpt,
    output logic        soft_irpt
);

    localparam int          AW        = $clog2(RAM_DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_DEPTH) << 2;

    logic [31:0] ram [RAM_DEPTH];

    state_t      state, nxt;
    region_t     dec, lat_region;
    logic [3:0]  cnt;
    logic [15:0] lat_off;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic [31:0] ram_q;
    logic [31:0] clint_rdata;
    logic        accept;
    logic        resp;
    logic        unused_instr;

    assign unused_instr = memory_instr;
    assign accept       = (state == S_IDLE) && memory_valid;
    assign resp         = (state == S_RESP);
    assign memory_ready = resp;

    // region decode of the incoming address
    always_comb begin
        dec = R_NONE;
        if ({1'b0, memory_addr} < RAM_BYTES)
            dec = R_RAM;
        else if (memory_addr[31:16] == CLINT_BASE[31:16])
            dec = R_CLINT;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    // next-state logic; RESP always returns to IDLE
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (memory_valid) nxt = (WAIT == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt == 4'd1) nxt = S_RESP;
            S_RESP: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // request latch and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            lat_off    <= '0;
            lat_wdata  <= '0;
            lat_wstrb  <= '0;
            lat_region <= R_NONE;
        end else if (accept) begin
            cnt        <= 4'(WAIT);
            lat_off    <= memory_addr[15:0];
            lat_wdata  <= memory_wdata;
            lat_wstrb  <= memory_wstrb;
            lat_region <= dec;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // RAM: read on accept, strobed write commits at end of RESP
    always_ff @(posedge clk) begin
        if (accept && dec == R_RAM)
            ram_q <= ram[memory_addr[AW+1:2]];
        if (resp && lat_region == R_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_wstrb[i])
                    ram[lat_off[AW+1:2]][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

    memory_responder_clint u_clint (
        .clk        (clk),
        .rst        (rst),
        .wr         (resp && lat_region == R_CLINT && lat_wstrb != 4'd0),
        .rd         (resp && lat_region == R_CLINT && lat_wstrb == 4'd0),
        .off        (lat_off),
        .wdata      (lat_wdata),
        .wstrb      (lat_wstrb),
        .rdata      (clint_rdata),
        .timer_irpt (timer_irpt),
        .soft_irpt  (soft_irpt)
    );

    // read data is only driven during the ready cycle
    always_comb begin
        memory_rdata = '0;
        if (resp && lat_wstrb == 4'd0) begin
            unique case (lat_region)
                R_RAM:   memory_rdata = ram_q;
                R_CLINT: memory_rdata = clint_rdata;
                default: memory_rdata = '0;
            endcase
        end
    end

endmodule
